// File: rtl/dco_fm_pkg.sv
// Shared types and constants for the DCO frequency meter.
// Optional build macro: DCO_FM_AVG_EN (4-window averaged result).
package dco_fm_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
  localparam int AVG_DEPTH = 4;
endpackage

// File: rtl/dco_fm_sync.sv
// Multi-flop synchroniser for dco_in with a rising-edge detector.
// 'load' re-primes the detector so the sample taken at window open is never a rise.
module dco_fm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic load,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q & ~load;
endmodule

// File: rtl/dco_freq_meter.sv
// Counts synchronised dco_in rising edges over a programmable clk window and
// publishes the count on a valid/ready port. Build macro: DCO_FM_AVG_EN.
module dco_freq_meter
  import dco_fm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dco_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  input  logic             ready,
  output logic             ovf,
  output logic             overrun
);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_SAT - 1'b1;

  state_t           state;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_int;
  logic             rise;

  dco_fm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dco_in),
    .load (state == ARM),
    .rise (rise)
  );

`ifdef DCO_FM_AVG_EN
  // hist[0] is the most recent completed window; the current one joins it in DONE
  logic [AVG_DEPTH-2:0][CNT_W-1:0] hist;
  logic [AVG_DEPTH-2:0]            ovf_hist;
  logic [2:0]                      nwin;
  logic [CNT_W+1:0]                avg_sum;

  always_comb begin
    avg_sum = {2'b00, edge_cnt};
    for (int i = 0; i < AVG_DEPTH-1; i++) avg_sum = avg_sum + {2'b00, hist[i]};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      overrun   <= 1'b0;
      win_len_q <= '0;
      win_cnt   <= '0;
      edge_cnt  <= '0;
      ovf_int   <= 1'b0;
`ifdef DCO_FM_AVG_EN
      hist      <= '0;
      ovf_hist  <= '0;
      nwin      <= '0;
`endif
    end else begin
      if (start) overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ARM;
          busy  <= 1'b1;
`ifdef DCO_FM_AVG_EN
          nwin  <= '0;
`endif
        end
        ARM: begin
          win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
          win_cnt   <= '0;
          edge_cnt  <= '0;
          ovf_int   <= 1'b0;
          state     <= MEASURE;
        end
        MEASURE: begin
          if (rise && edge_cnt != CNT_SAT) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == CNT_PRE) ovf_int <= 1'b1;
          end
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == win_len_q - 1'b1) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
`ifdef DCO_FM_AVG_EN
          hist     <= {hist[AVG_DEPTH-3:0], edge_cnt};
          ovf_hist <= {ovf_hist[AVG_DEPTH-3:0], ovf_int};
          if (nwin != 3'(AVG_DEPTH)) nwin <= nwin + 1'b1;
          if (nwin >= 3'(AVG_DEPTH-1)) begin
            if (valid && !ready) overrun <= 1'b1;
            count <= CNT_W'(avg_sum >> 2);
            ovf   <= ovf_int | (|ovf_hist);
            valid <= 1'b1;
          end
          if (continuous || nwin < 3'(AVG_DEPTH-1)) begin
            state <= ARM;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
`else
          // new result overrides a same-cycle accept, so valid stays high
          if (valid && !ready) overrun <= 1'b1;
          count <= edge_cnt;
          ovf   <= ovf_int;
          valid <= 1'b1;
          if (continuous) begin
            state <= ARM;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dco_freq_meter.sv
// Directed bench for dco_freq_meter: a 16-bit instance and a 4-bit instance share stimulus.
module tb_dco_freq_meter;
  logic        clk = 1'b0;
  logic        rst_n, dco_in, start, continuous, ready;
  logic [15:0] win_len;
  logic        busy_a, valid_a, ovf_a, overrun_a;
  logic [15:0] count_a;
  logic        busy_b, valid_b, ovf_b, overrun_b;
  logic [3:0]  count_b;
  int          dco_half = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // dco edges sit 3 ns after a 10 ns grid so they never coincide with clk edges
  initial begin
    dco_in = 1'b0;
    #3;
    forever begin
      if (dco_half == 0) begin
        dco_in = 1'b0;
        #10;
      end else begin
        #(dco_half) dco_in = ~dco_in;
      end
    end
  end

  dco_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .start(start), .continuous(continuous),
    .win_len(win_len), .busy(busy_a), .count(count_a), .valid(valid_a), .ready(ready),
    .ovf(ovf_a), .overrun(overrun_a)
  );

  dco_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .start(start), .continuous(continuous),
    .win_len(win_len), .busy(busy_b), .count(count_b), .valid(valid_b), .ready(ready),
    .ovf(ovf_b), .overrun(overrun_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ready = 1'b0; win_len = 16'd0;
    ticks(2);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_overrun", overrun_a, 0);
    rst_n = 1'b1;
    tick();

    // period 4 clk, 100-cycle window; a stray start mid-window is ignored
    dco_half = 20; win_len = 16'd100;
    ticks(4);
    pulse_start();
    chk("t1_busy", busy_a, 1);
    ticks(50);
    pulse_start();
    ticks(50);
    chk("t1_valid_early", valid_a, 0);
    chk("t1_busy_done", busy_a, 0);
    tick();
    chk("t1_valid", valid_a, 1);
    chk_rng("t1_count", count_a, 24, 26);
    chk("t1_ovf", ovf_a, 0);
    accept();
    chk("t1_valid_clr", valid_a, 0);
    chk_rng("t1_count_held", count_a, 24, 26);

    // dco low, win_len 0 acts as a 1-cycle window
    dco_half = 0; win_len = 16'd0;
    ticks(5);
    pulse_start();
    ticks(2);
    chk("t2_valid_early", valid_a, 0);
    tick();
    chk("t2_valid", valid_a, 1);
    chk("t2_count", count_a, 0);
    chk("t2_ovf", ovf_a, 0);
    accept();

    // period 2 clk, 64 cycles: 32 rises, saturates the 4-bit counter
    dco_half = 10; win_len = 16'd64;
    ticks(5);
    pulse_start();
    ticks(65);
    tick();
    chk("t3_valid_a", valid_a, 1);
    chk("t3_count_a", count_a, 32);
    chk("t3_ovf_a", ovf_a, 0);
    chk("t3_valid_b", valid_b, 1);
    chk("t3_count_b", count_b, 15);
    chk("t3_ovf_b", ovf_b, 1);
    accept();

    // continuous with ready low: second result overwrites the first
    dco_half = 0; win_len = 16'd8; continuous = 1'b1;
    ticks(5);
    pulse_start();
    ticks(9);
    tick();
    chk("t4_valid1", valid_a, 1);
    chk("t4_count1", count_a, 0);
    chk("t4_overrun1", overrun_a, 0);
    dco_half = 10; continuous = 1'b0;
    ticks(10);
    chk("t4_valid2", valid_a, 1);
    chk_rng("t4_count2", count_a, 3, 4);
    chk("t4_overrun2", overrun_a, 1);
    tick();
    chk("t4_idle", busy_a, 0);
    pulse_start();
    chk("t4_overrun_clr", overrun_a, 0);
    ticks(10);
    chk("t4_valid3", valid_a, 1);
    accept();

    // reset mid-measure, then a fresh measurement
    dco_half = 20; win_len = 16'd100;
    ticks(3);
    pulse_start();
    ticks(20);
    rst_n = 1'b0;
    tick();
    chk("t5_busy", busy_a, 0);
    chk("t5_valid", valid_a, 0);
    chk("t5_count", count_a, 0);
    rst_n = 1'b1;
    tick();
    win_len = 16'd40;
    pulse_start();
    ticks(41);
    chk("t5_valid_early", valid_a, 0);
    tick();
    chk("t5_valid2", valid_a, 1);
    chk_rng("t5_count2", count_a, 9, 11);
    chk("t5_ovf", ovf_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
